// File: rtl/sha1_padder.sv
// rtl/sha1_padder.sv - SHA-1 message padder: byte stream in, 512-bit padded blocks out
//
// Purpose:
//   Packs message bytes big-endian into 512-bit blocks and appends the SHA-1
//   padding: 0x80, zero fill and the 64-bit message bit length. A second
//   block is emitted whenever the padding does not fit behind the data.
//
// Optional feature (macro GIT_BLOB_HEADER_EN):
//   When defined, a message starts with a byte_valid_i pulse in IDLE. That
//   pulse samples len_i, and the padder writes the git object header
//   "blob <decimal len_i>\0" ahead of the payload. Header bytes count towards
//   the length field. When undefined, len_i is ignored and IDLE accepts the
//   first payload byte directly.
//
// Ports:
//   clk_i          sole clock, all state on the rising edge
//   rst_i          asynchronous active-high reset
//   byte_i         message byte
//   byte_valid_i   byte_i valid
//   byte_last_i    byte_i is the final message byte
//   byte_ready_o   byte accepted when byte_valid_i && byte_ready_o
//   len_i          payload byte count (header mode only)
//   block_o        padded 512-bit block, first byte in the MSBs
//   block_valid_o  block_o valid
//   block_ready_i  block taken when block_valid_o && block_ready_i
//   block_last_o   block_o is the final block of the message

module sha1_padder #(
    parameter int LEN_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [7:0]       byte_i,
    input  logic             byte_valid_i,
    input  logic             byte_last_i,
    output logic             byte_ready_o,
    input  logic [LEN_W-1:0] len_i,
    output logic [511:0]     block_o,
    output logic             block_valid_o,
    input  logic             block_ready_i,
    output logic             block_last_o
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HDR,
        S_FILL,
        S_EMIT,
        S_TAIL
    } state_t;

    state_t         r_state;
    logic [60:0]    r_count;       // bytes so far, header included
    logic [5:0]     r_idx;         // byte slot of the next write
    logic [511:0]   r_block;
    logic           r_valid;
    logic           r_last;
    logic           r_pend_tail;   // a length-only block follows the current one
    logic           r_pend_80;     // that trailing block also carries the 0x80 marker
    logic           r_resume_hdr;  // after a full block, continue with the header

    logic           w_accept;
    logic           w_is_last;
    logic [60:0]    w_count_inc;
    logic [8:0]     w_pos;
    logic [8:0]     w_pad_pos;
    logic [7:0]     w_in_byte;
    logic [7:0]     w_hdr_byte;
    logic [511:0]   w_blk_wr;
    logic [511:0]   w_tail;

`ifdef GIT_BLOB_HEADER_EN
    // Three bits never hold more than one decimal digit, so this bounds the
    // digit count of len_i from above.
    localparam int ND = (LEN_W + 2) / 3;

    logic [4*ND-1:0] r_bcd;
    logic [7:0]      r_ndig;
    logic [7:0]      r_hdr_pos;
    logic [4*ND-1:0] w_bcd;
    logic [7:0]      w_ndig;
    logic [7:0]      w_dig_idx;
    logic            w_hdr_done;

    // Binary to BCD (shift-and-add-3), evaluated on len_i when it is sampled.
    always_comb begin
        w_bcd  = '0;
        w_ndig = 8'd1;
        for (int i = LEN_W - 1; i >= 0; i--) begin
            for (int d = 0; d < ND; d++) begin
                if (w_bcd[4*d +: 4] >= 4'd5)
                    w_bcd[4*d +: 4] = w_bcd[4*d +: 4] + 4'd3;
            end
            w_bcd = {w_bcd[4*ND-2:0], len_i[i]};
        end
        // Highest nonzero digit sets the printed width; zero prints as "0".
        for (int d = 1; d < ND; d++) begin
            if (w_bcd[4*d +: 4] != 4'd0)
                w_ndig = 8'(d + 1);
        end
    end

    // Header byte for the current header position: "blob ", digits, 0x00.
    always_comb begin
        w_hdr_byte = 8'h00;
        w_hdr_done = 1'b0;
        w_dig_idx  = 8'd0;
        if (r_hdr_pos < 8'd5) begin
            case (r_hdr_pos[2:0])
                3'd0:    w_hdr_byte = 8'h62;
                3'd1:    w_hdr_byte = 8'h6c;
                3'd2:    w_hdr_byte = 8'h6f;
                3'd3:    w_hdr_byte = 8'h62;
                default: w_hdr_byte = 8'h20;
            endcase
        end else if (r_hdr_pos < 8'd5 + r_ndig) begin
            // Most significant digit first.
            w_dig_idx = r_ndig - 8'd1 - (r_hdr_pos - 8'd5);
            for (int d = 0; d < ND; d++) begin
                if (w_dig_idx == 8'(d))
                    w_hdr_byte = {4'h3, r_bcd[4*d +: 4]};
            end
        end else begin
            w_hdr_done = 1'b1;
        end
    end

    assign byte_ready_o = !rst_i && (r_state == S_FILL);
`else
    logic w_unused_len;
    assign w_unused_len = ^len_i;
    assign w_hdr_byte   = 8'h00;
    assign byte_ready_o = !rst_i && ((r_state == S_FILL) || (r_state == S_IDLE));
`endif

    assign w_accept    = byte_valid_i && byte_ready_o;
    assign w_is_last   = w_accept && byte_last_i;
    assign w_count_inc = r_count + 61'd1;
    // MSB of byte slot k is bit 511-8k; the pad marker goes one slot later.
    assign w_pos       = 9'd511 - {r_idx, 3'b000};
    assign w_pad_pos   = w_pos - 9'd8;
    assign w_in_byte   = (r_state == S_HDR) ? w_hdr_byte : byte_i;
    assign w_tail      = {(r_pend_80 ? 8'h80 : 8'h00), 440'd0, r_count, 3'b000};

    // Current block with this cycle's byte, plus padding when it is the last.
    always_comb begin
        w_blk_wr = r_block;
        w_blk_wr[w_pos -: 8] = w_in_byte;
        if (w_is_last && (r_idx != 6'd63))
            w_blk_wr[w_pad_pos -: 8] = 8'h80;
        if (w_is_last && (r_idx <= 6'd54))
            w_blk_wr[63:0] = {w_count_inc, 3'b000};
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state      <= S_IDLE;
            r_count      <= '0;
            r_idx        <= '0;
            r_block      <= '0;
            r_valid      <= 1'b0;
            r_last       <= 1'b0;
            r_pend_tail  <= 1'b0;
            r_pend_80    <= 1'b0;
            r_resume_hdr <= 1'b0;
`ifdef GIT_BLOB_HEADER_EN
            r_bcd        <= '0;
            r_ndig       <= '0;
            r_hdr_pos    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_FILL: begin
`ifdef GIT_BLOB_HEADER_EN
                    if (r_state == S_IDLE) begin
                        if (byte_valid_i) begin
                            r_bcd     <= w_bcd;
                            r_ndig    <= w_ndig;
                            r_hdr_pos <= 8'd0;
                            r_state   <= S_HDR;
                        end
                    end else
`endif
                    if (w_accept) begin
                        r_block <= w_blk_wr;
                        r_count <= w_count_inc;
                        r_idx   <= r_idx + 6'd1;
                        if (byte_last_i) begin
                            r_valid      <= 1'b1;
                            r_last       <= (r_idx <= 6'd54);
                            r_pend_tail  <= (r_idx > 6'd54);
                            r_pend_80    <= (r_idx == 6'd63);
                            r_resume_hdr <= 1'b0;
                            r_state      <= S_EMIT;
                        end else if (r_idx == 6'd63) begin
                            r_valid      <= 1'b1;
                            r_last       <= 1'b0;
                            r_pend_tail  <= 1'b0;
                            r_resume_hdr <= 1'b0;
                            r_state      <= S_EMIT;
                        end else begin
                            r_state <= S_FILL;
                        end
                    end
                end

`ifdef GIT_BLOB_HEADER_EN
                S_HDR: begin
                    // Header bytes are never the final message byte.
                    r_block   <= w_blk_wr;
                    r_count   <= w_count_inc;
                    r_idx     <= r_idx + 6'd1;
                    r_hdr_pos <= r_hdr_pos + 8'd1;
                    if (r_idx == 6'd63) begin
                        r_valid      <= 1'b1;
                        r_last       <= 1'b0;
                        r_pend_tail  <= 1'b0;
                        r_resume_hdr <= !w_hdr_done;
                        r_state      <= S_EMIT;
                    end else if (w_hdr_done) begin
                        r_state <= S_FILL;
                    end
                end
`endif

                S_EMIT: begin
                    if (block_ready_i) begin
                        if (r_last) begin
                            r_state     <= S_IDLE;
                            r_count     <= '0;
                            r_idx       <= '0;
                            r_block     <= '0;
                            r_valid     <= 1'b0;
                            r_last      <= 1'b0;
                            r_pend_tail <= 1'b0;
                            r_pend_80   <= 1'b0;
                        end else if (r_pend_tail) begin
                            r_block <= w_tail;
                            r_last  <= 1'b1;
                            r_state <= S_TAIL;
                        end else begin
                            r_block <= '0;
                            r_idx   <= '0;
                            r_valid <= 1'b0;
                            r_state <= r_resume_hdr ? S_HDR : S_FILL;
                        end
                    end
                end

                S_TAIL: begin
                    if (block_ready_i) begin
                        r_state     <= S_IDLE;
                        r_count     <= '0;
                        r_idx       <= '0;
                        r_block     <= '0;
                        r_valid     <= 1'b0;
                        r_last      <= 1'b0;
                        r_pend_tail <= 1'b0;
                        r_pend_80   <= 1'b0;
                    end
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign block_o       = r_block;
    assign block_valid_o = r_valid;
    assign block_last_o  = r_last;

endmodule
